mealy_seq_gen: RTL and testbench

- Serial pattern transmitter: drives the single-bit `x` stream that `mealy_seq` detectors consume.
- Accepts parallel frames of up to WIDTH bits through a valid/ready load port and buffers one frame.
- Shifts each frame out MSB-first, one bit per clock, with a programmable idle gap between frames.
- Used as the stimulus source for detector benches and as the serial driver in the datapath.

---
 rtl/mealy_seq_gen_pkg.sv | 14 +
 rtl/mealy_seq_gen.sv | 126 ++++++++++++
 tb/tb_mealy_seq_gen.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mealy_seq_gen_pkg.sv
// Shared types and defaults for the serial pattern transmitter
// and the mealy_seq detector benches.
package mealy_seq_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_GAP   = 1;

endpackage

// File: rtl/mealy_seq_gen.sv
// Serial pattern transmitter: one-frame holding buffer feeding an
// MSB-first shifter with a programmable idle gap between frames.
module mealy_seq_gen
    import mealy_seq_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GAP   = DEF_GAP,
    parameter int LW    = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data,
    input  logic [LW-1:0]    len,
    output logic             x,
    output logic             x_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int            GW       = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [LW-1:0] FULL_LEN = LW'(WIDTH);
    localparam logic [GW-1:0] GAP_INIT = GW'(GAP);

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [LW-1:0]    r_cnt;
    logic [GW-1:0]    r_gap;
    logic             r_buf_full;
    logic [WIDTH-1:0] r_buf_data;
    logic [LW-1:0]    r_buf_len;

    logic             w_accept;
    logic             w_last;
    logic             w_gap_end;
    logic             w_xfer;
    logic [LW-1:0]    w_eff_len;
    logic [WIDTH-1:0] w_aligned;

    assign load_ready = !r_buf_full;
    assign w_accept   = load_valid && !r_buf_full;
    assign w_eff_len  = (len == '0 || len > FULL_LEN) ? FULL_LEN : len;

    assign w_last    = (r_state == ST_SHIFT) && (r_cnt == LW'(1));
    assign w_gap_end = (r_state == ST_GAP) && (r_gap == GW'(1));
    assign w_xfer    = r_buf_full &&
                       ((r_state == ST_IDLE) || w_gap_end ||
                        (w_last && (GAP == 0)));

    // Left-align the frame so its first bit sits at the MSB.
    assign w_aligned = r_buf_data << (FULL_LEN - r_buf_len);

    assign x          = r_shreg[WIDTH-1];
    assign x_valid    = (r_state == ST_SHIFT);
    assign frame_done = w_last;
    assign busy       = (r_state != ST_IDLE) || r_buf_full;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_buf_full <= 1'b0;
            r_buf_data <= '0;
            r_buf_len  <= '0;
        end else if (w_accept) begin
            r_buf_full <= 1'b1;
            r_buf_data <= data;
            r_buf_len  <= w_eff_len;
        end else if (w_xfer) begin
            r_buf_full <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_gap   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_state <= ST_SHIFT;
                        r_shreg <= w_aligned;
                        r_cnt   <= r_buf_len;
                    end
                end
                ST_SHIFT: begin
                    if (!w_last) begin
                        r_shreg <= r_shreg << 1;
                        r_cnt   <= r_cnt - LW'(1);
                    end else if (GAP > 0) begin
                        r_state <= ST_GAP;
                        r_gap   <= GAP_INIT;
                        r_shreg <= '0;
                        r_cnt   <= '0;
                    end else if (w_xfer) begin
                        r_shreg <= w_aligned;
                        r_cnt   <= r_buf_len;
                    end else begin
                        r_state <= ST_IDLE;
                        r_shreg <= '0;
                        r_cnt   <= '0;
                    end
                end
                ST_GAP: begin
                    if (!w_gap_end) begin
                        r_gap <= r_gap - GW'(1);
                    end else if (w_xfer) begin
                        r_state <= ST_SHIFT;
                        r_gap   <= '0;
                        r_shreg <= w_aligned;
                        r_cnt   <= r_buf_len;
                    end else begin
                        r_state <= ST_IDLE;
                        r_gap   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mealy_seq_gen.sv
// Directed bench for mealy_seq_gen: a GAP=1 instance and a GAP=0
// instance share clock, reset and the data/len bus.
module tb_mealy_seq_gen;
    import mealy_seq_gen_pkg::*;

    localparam int W  = DEF_WIDTH;
    localparam int LW = $clog2(W + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          lv1   = 1'b0;
    logic          lv0   = 1'b0;
    logic [W-1:0]  data  = '0;
    logic [LW-1:0] len   = '0;
    logic rdy1, x1, xv1, fd1, busy1;
    logic rdy0, x0, xv0, fd0, busy0;
    int vecs = 0;
    int errs = 0;

    always #5 clock = ~clock;

    mealy_seq_gen #(.WIDTH(W), .GAP(1)) dut1 (
        .clock(clock), .reset(reset),
        .load_valid(lv1), .load_ready(rdy1),
        .data(data), .len(len),
        .x(x1), .x_valid(xv1), .frame_done(fd1), .busy(busy1)
    );

    mealy_seq_gen #(.WIDTH(W), .GAP(0)) dut0 (
        .clock(clock), .reset(reset),
        .load_valid(lv0), .load_ready(rdy0),
        .data(data), .len(len),
        .x(x0), .x_valid(xv0), .frame_done(fd0), .busy(busy0)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        vecs++;
        if ({x1, xv1, fd1, busy1, rdy1} !== 5'b00001) begin
            errs++;
            $display("FAIL reset_g1 got %b want 00001",
                     {x1, xv1, fd1, busy1, rdy1});
        end
        vecs++;
        if ({x0, xv0, fd0, busy0, rdy0} !== 5'b00001) begin
            errs++;
            $display("FAIL reset_g0 got %b want 00001",
                     {x0, xv0, fd0, busy0, rdy0});
        end
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            vecs++;
            if ({x1, xv1, busy1, rdy1, x0, xv0, busy0, rdy0} !== 8'b0001_0001) begin
                errs++;
                $display("FAIL idle[%0d] got %b want 00010001", i,
                         {x1, xv1, busy1, rdy1, x0, xv0, busy0, rdy0});
            end
        end
    endtask

    task automatic test_single();
        logic [3:0] exp [6] = '{4'b1101, 4'b1101, 4'b1101,
                                4'b0111, 4'b0001, 4'b0000};
        data = 8'h0E;
        len  = 4'd4;
        lv1  = 1'b1;
        tick();
        lv1 = 1'b0;
        vecs++;
        if ({rdy1, busy1, xv1} !== 3'b010) begin
            errs++;
            $display("FAIL single_accept got %b want 010", {rdy1, busy1, xv1});
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            vecs++;
            if ({x1, xv1, fd1, busy1} !== exp[i]) begin
                errs++;
                $display("FAIL single[%0d] got %b want %b", i,
                         {x1, xv1, fd1, busy1}, exp[i]);
            end
        end
    endtask

    task automatic test_length();
        logic [7:0] td [4] = '{8'hA5, 8'hA5, 8'h01, 8'h3C};
        logic [3:0] tl [4] = '{4'd0, 4'd9, 4'd1, 4'd6};
        logic [7:0] te [4] = '{8'b10100101, 8'b10100101,
                               8'b10000000, 8'b11110000};
        int         tn [4] = '{8, 8, 1, 6};
        for (int r = 0; r < 4; r++) begin
            data = td[r];
            len  = tl[r];
            lv1  = 1'b1;
            tick();
            lv1 = 1'b0;
            tick();
            for (int i = 0; i < tn[r]; i++) begin
                vecs++;
                if ({x1, xv1, fd1} !== {te[r][7-i], 1'b1, (i == tn[r] - 1)}) begin
                    errs++;
                    $display("FAIL len_row%0d_bit%0d got %b want %b", r, i,
                             {x1, xv1, fd1},
                             {te[r][7-i], 1'b1, (i == tn[r] - 1)});
                end
                tick();
            end
            vecs++;
            if ({x1, xv1, fd1, busy1} !== 4'b0001) begin
                errs++;
                $display("FAIL len_row%0d_gap got %b want 0001", r,
                         {x1, xv1, fd1, busy1});
            end
            tick();
            vecs++;
            if ({xv1, busy1, rdy1} !== 3'b001) begin
                errs++;
                $display("FAIL len_row%0d_idle got %b want 001", r,
                         {xv1, busy1, rdy1});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp [5] = '{3'b110, 3'b111, 3'b110, 3'b010, 3'b111};
        logic       acc;
        int         nacc = 0;
        data = 8'h03;
        len  = 4'd2;
        lv0  = 1'b1;
        tick();
        vecs++;
        if (rdy0 !== 1'b0) begin
            errs++;
            $display("FAIL b2b_ready got %b want 0", rdy0);
        end
        data = 8'h05;
        len  = 4'd3;
        for (int i = 0; i < 5; i++) begin
            acc = lv0 && rdy0;
            tick();
            if (acc) begin
                lv0 = 1'b0;
                nacc++;
            end
            vecs++;
            if ({x0, xv0, fd0} !== exp[i]) begin
                errs++;
                $display("FAIL b2b[%0d] got %b want %b", i,
                         {x0, xv0, fd0}, exp[i]);
            end
        end
        vecs++;
        if (nacc !== 1) begin
            errs++;
            $display("FAIL b2b_accepts got %0d want 1", nacc);
        end
        tick();
        vecs++;
        if ({xv0, busy0, rdy0} !== 3'b001) begin
            errs++;
            $display("FAIL b2b_idle got %b want 001", {xv0, busy0, rdy0});
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] fdat [3] = '{8'h0B, 8'h02, 8'h07};
        logic [3:0] flen [3] = '{4'd4, 4'd2, 4'd3};
        logic [3:0] exp [14] = '{4'b0000, 4'b1101, 4'b0100, 4'b1100,
                                 4'b1110, 4'b0000, 4'b1101, 4'b0110,
                                 4'b0000, 4'b1101, 4'b1101, 4'b1111,
                                 4'b0001, 4'b0001};
        logic       acc;
        int         idx = 0;
        data = fdat[0];
        len  = flen[0];
        lv1  = 1'b1;
        for (int i = 0; i < 14; i++) begin
            acc = lv1 && rdy1;
            tick();
            if (acc) begin
                idx++;
                if (idx < 3) begin
                    data = fdat[idx];
                    len  = flen[idx];
                end else begin
                    lv1 = 1'b0;
                end
            end
            vecs++;
            if ({x1, xv1, fd1, rdy1} !== exp[i]) begin
                errs++;
                $display("FAIL bp[%0d] got %b want %b", i,
                         {x1, xv1, fd1, rdy1}, exp[i]);
            end
        end
        vecs++;
        if (idx !== 3) begin
            errs++;
            $display("FAIL bp_accepts got %0d want 3", idx);
        end
        lv1 = 1'b0;
    endtask

    task automatic test_reset_mid();
        data = 8'hFF;
        len  = 4'd8;
        lv1  = 1'b1;
        tick();
        data = 8'hAA;
        tick();
        tick();
        lv1 = 1'b0;
        tick();
        vecs++;
        if ({x1, xv1, busy1, rdy1} !== 4'b1110) begin
            errs++;
            $display("FAIL rst_mid_pre got %b want 1110",
                     {x1, xv1, busy1, rdy1});
        end
        #2;
        reset = 1'b0;
        #1;
        vecs++;
        if ({x1, xv1, fd1, busy1, rdy1} !== 5'b00001) begin
            errs++;
            $display("FAIL rst_mid_async got %b want 00001",
                     {x1, xv1, fd1, busy1, rdy1});
        end
        data = 8'hFF;
        lv1  = 1'b1;
        tick();
        lv1 = 1'b0;
        vecs++;
        if ({busy1, rdy1} !== 2'b01) begin
            errs++;
            $display("FAIL rst_mid_load_ignored got %b want 01", {busy1, rdy1});
        end
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            vecs++;
            if ({x1, xv1, busy1, rdy1} !== 4'b0001) begin
                errs++;
                $display("FAIL rst_mid_after[%0d] got %b want 0001", i,
                         {x1, xv1, busy1, rdy1});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_length();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
